// File: rtl/u_b_potential_sequencer_pkg.sv
// u_b_potential_sequencer_pkg: shared FSM encoding and lane geometry for the potential sequencer.
package u_b_potential_sequencer_pkg;
  localparam int NEURONS_PER_GROUP = 16;
  localparam int POT_W = 8;
  localparam int BETA_W = 4;
  localparam int GRP_POT_W = NEURONS_PER_GROUP * POT_W;
  localparam int GRP_BETA_W = NEURONS_PER_GROUP * BETA_W;
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WAIT,
    S_ISSUE,
    S_COLLECT,
    S_WB,
    S_DONE
  } state_t;
endpackage

// File: rtl/u_b_potential_sequencer.sv
// u_b_potential_sequencer: walks neuron groups SRAM -> decay -> integrate -> save -> SRAM once per timestep.
module u_b_potential_sequencer
  import u_b_potential_sequencer_pkg::*;
#(
  parameter int N_GROUPS = 8,
  parameter int ADDR_W = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_rd_en,
  input  logic [GRP_POT_W-1:0]         mem_rd_pot,
  input  logic [GRP_BETA_W-1:0]        mem_rd_beta,
  output logic                         mem_wr_en,
  output logic [GRP_POT_W-1:0]         mem_wr_data,
  output logic [GRP_POT_W-1:0]         load_16n_potential_in,
  output logic [GRP_BETA_W-1:0]        load_16n_beta_in,
  input  logic [GRP_POT_W-1:0]         load_16n_potential_out,
  output logic                         int_valid,
  input  logic                         int_ready,
  output logic [GRP_POT_W-1:0]         int_potential,
  input  logic                         res_valid,
  input  logic [GRP_POT_W-1:0]         res_potential,
  input  logic [NEURONS_PER_GROUP-1:0] res_spk,
  output logic [GRP_POT_W-1:0]         save_16n_potential_in,
  output logic [NEURONS_PER_GROUP-1:0] save_16n_spk_in,
  input  logic [GRP_POT_W-1:0]         save_16n_potential_out,
  output logic                         spk_valid,
  output logic [ADDR_W-1:0]            spk_group,
  output logic [NEURONS_PER_GROUP-1:0] spk_out
);
  localparam logic [ADDR_W-1:0] G_LAST = ADDR_W'(N_GROUPS - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] g_q, g_d;
  logic [GRP_POT_W-1:0] load_pot_q, load_pot_d, save_pot_q, save_pot_d;
  logic [GRP_BETA_W-1:0] load_beta_q, load_beta_d;
  logic [NEURONS_PER_GROUP-1:0] spk_q, spk_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      g_q <= '0;
      load_pot_q <= '0;
      load_beta_q <= '0;
      save_pot_q <= '0;
      spk_q <= '0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      load_pot_q <= load_pot_d;
      load_beta_q <= load_beta_d;
      save_pot_q <= save_pot_d;
      spk_q <= spk_d;
    end
  end
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    load_pot_d = load_pot_q;
    load_beta_d = load_beta_q;
    save_pot_d = save_pot_q;
    spk_d = spk_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_RD;
        g_d = '0;
      end
      S_RD: state_d = S_WAIT;
      S_WAIT: begin
        load_pot_d = mem_rd_pot;
        load_beta_d = mem_rd_beta;
        state_d = S_ISSUE;
      end
      S_ISSUE: state_d = int_ready ? S_COLLECT : S_ISSUE;
      S_COLLECT: if (res_valid) begin
        save_pot_d = res_potential;
        spk_d = res_spk;
        state_d = S_WB;
      end
      S_WB: begin
        state_d = (g_q == G_LAST) ? S_DONE : S_RD;
        g_d = (g_q == G_LAST) ? g_q : g_q + 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        g_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // Strobes decode straight from the state register so an async reset kills them immediately.
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  assign mem_addr = busy ? g_q : '0;
  assign mem_rd_en = state_q == S_RD;
  assign mem_wr_en = state_q == S_WB;
  assign mem_wr_data = save_16n_potential_out;
  assign load_16n_potential_in = load_pot_q;
  assign load_16n_beta_in = load_beta_q;
  assign int_valid = state_q == S_ISSUE;
  assign int_potential = load_16n_potential_out;
  assign save_16n_potential_in = save_pot_q;
  assign save_16n_spk_in = spk_q;
  assign spk_valid = state_q == S_WB;
  assign spk_group = g_q;
  assign spk_out = spk_q;
endmodule
